// File: rtl/store_queue_pkg.sv
// Shared LSQ types: FU/LSQ packets, memory access sizes, store-queue entry and load FSM states.
`ifndef LSQ_IDX_LEN
`define LSQ_IDX_LEN 3
`endif
`ifndef XLEN
`define XLEN 32
`endif

package store_queue_pkg;

  localparam int LSQ_IDX_LEN = `LSQ_IDX_LEN;
  localparam int XLEN        = `XLEN;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef struct packed {
    logic                   valid;
    logic                   load;
    logic                   store;
    logic [XLEN-1:0]        addr;
    logic [XLEN-1:0]        value;
    logic [LSQ_IDX_LEN-1:0] sq_pos;
    MEM_SIZE                mem_size;
  } FU_LSQ_PACKET;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] value;
  } LSQ_FU_PACKET;

  typedef struct packed {
    logic            addr_valid;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    MEM_SIZE         size;
  } SQ_ENTRY;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4,
    DROP = 3'd5
  } LD_STATE;

  // Anything wider than a word is clipped to the 32-bit datapath.
  function automatic logic [2:0] size_bytes(input MEM_SIZE s);
    case (s)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] size_mask(input MEM_SIZE s);
    case (s)
      BYTE:    return XLEN'(32'h0000_00FF);
      HALF:    return XLEN'(32'h0000_FFFF);
      default: return XLEN'(32'hFFFF_FFFF);
    endcase
  endfunction

endpackage

// File: rtl/store_queue_fwd.sv
// Store-to-load forwarding search: scans stores older than a load, reports unresolved
// addresses and the youngest same-word store, whether it covers the load, and its word image.
module sq_fwd_search
  import store_queue_pkg::*;
#(
  parameter int SQ_DEPTH = 2**LSQ_IDX_LEN
) (
  input  SQ_ENTRY                entries [SQ_DEPTH],
  input  logic [LSQ_IDX_LEN-1:0] head_idx,
  input  logic [LSQ_IDX_LEN:0]   n_older,
  input  logic [XLEN-1:0]        ld_addr,
  input  MEM_SIZE                ld_size,
  output logic                   unknown,
  output logic                   match,
  output logic                   covers,
  output logic [XLEN-1:0]        fwd_word
);

  localparam int IW = LSQ_IDX_LEN;

  logic [IW-1:0] idx;
  logic [2:0]    s_lo, s_hi, l_lo, l_hi;

  // Walking oldest to youngest lets the youngest matching store win by overwriting.
  always_comb begin
    unknown  = 1'b0;
    match    = 1'b0;
    covers   = 1'b0;
    fwd_word = '0;
    idx      = '0;
    s_lo     = '0;
    s_hi     = '0;
    l_lo     = {1'b0, ld_addr[1:0]};
    l_hi     = l_lo + size_bytes(ld_size);
    for (int k = 0; k < SQ_DEPTH; k++) begin
      idx = head_idx + IW'(k);
      if (k < int'(n_older)) begin
        if (!entries[idx].addr_valid) begin
          unknown = 1'b1;
        end else if (entries[idx].addr[XLEN-1:2] == ld_addr[XLEN-1:2]) begin
          s_lo     = {1'b0, entries[idx].addr[1:0]};
          s_hi     = s_lo + size_bytes(entries[idx].size);
          match    = 1'b1;
          covers   = (s_lo <= l_lo) && (s_hi >= l_hi);
          fwd_word = entries[idx].data << {entries[idx].addr[1:0], 3'b000};
        end
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// Circular store queue with commit/drain pointers and a single-load FSM that either
// forwards from an older store or reads memory. SQ_DEPTH must equal 2**LSQ_IDX_LEN.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int SQ_DEPTH = 2**LSQ_IDX_LEN
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alloc_en,
  output logic [LSQ_IDX_LEN-1:0] storeq_pos,
  output logic                   sq_full,
  input  FU_LSQ_PACKET           fu_lsq,
  output LSQ_FU_PACKET           lsq_fu,
  input  logic                   retire_store,
  input  logic                   squash,
  output logic                   mem_rd_req,
  output logic [XLEN-1:0]        mem_rd_addr,
  input  logic                   mem_rd_gnt,
  input  logic                   mem_rd_valid,
  input  logic [XLEN-1:0]        mem_rd_data,
  output logic                   mem_wr_en,
  output logic [XLEN-1:0]        mem_wr_addr,
  output logic [XLEN-1:0]        mem_wr_data,
  output MEM_SIZE                mem_wr_size,
  input  logic                   mem_wr_ready
);

  localparam int IW = LSQ_IDX_LEN;

  SQ_ENTRY         entries [SQ_DEPTH];
  logic [IW:0]     head, commit, tail, commit_next;
  logic [IW-1:0]   rel_pos;
  logic [IW:0]     n_older;
  logic            fwd_unknown, fwd_match, fwd_covers;
  logic [XLEN-1:0] fwd_word;
  LD_STATE         state, state_next;
  logic [XLEN-1:0] ld_addr, ld_data;
  MEM_SIZE         ld_size;

  assign sq_full     = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
  assign storeq_pos  = tail[IW-1:0];
  assign mem_wr_en   = (head != commit);
  assign mem_wr_addr = entries[head[IW-1:0]].addr;
  assign mem_wr_data = entries[head[IW-1:0]].data;
  assign mem_wr_size = entries[head[IW-1:0]].size;
  assign mem_rd_addr = {ld_addr[XLEN-1:2], 2'b00};

  // A load tagged at the head slot of a full queue sees every entry as older.
  assign rel_pos = fu_lsq.sq_pos - head[IW-1:0];
  assign n_older = (rel_pos == '0 && sq_full) ? (IW+1)'(SQ_DEPTH) : {1'b0, rel_pos};

  sq_fwd_search #(.SQ_DEPTH(SQ_DEPTH)) u_fwd_search (
    .entries  (entries),
    .head_idx (head[IW-1:0]),
    .n_older  (n_older),
    .ld_addr  (fu_lsq.addr),
    .ld_size  (fu_lsq.mem_size),
    .unknown  (fwd_unknown),
    .match    (fwd_match),
    .covers   (fwd_covers),
    .fwd_word (fwd_word)
  );

  always_comb begin
    commit_next = commit;
    if (retire_store && (commit != tail)) commit_next = commit + 1'b1;
  end

  // Squash rewinds the tail to the commit point so committed stores keep draining.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head   <= '0;
      commit <= '0;
      tail   <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) entries[i] <= '0;
    end else begin
      commit <= commit_next;
      if (mem_wr_en && mem_wr_ready) begin
        head <= head + 1'b1;
        entries[head[IW-1:0]].addr_valid <= 1'b0;
      end
      if (squash) begin
        tail <= commit_next;
      end else begin
        if (alloc_en && !sq_full) begin
          entries[tail[IW-1:0]].addr_valid <= 1'b0;
          tail <= tail + 1'b1;
        end
        if (fu_lsq.valid && fu_lsq.store) begin
          entries[fu_lsq.sq_pos] <= '{addr_valid: 1'b1, addr: fu_lsq.addr,
                                      data: fu_lsq.value, size: fu_lsq.mem_size};
        end
      end
    end
  end

  // The forwarded word is latched on entry to FWD so a drain of that store cannot disturb it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ld_addr <= '0;
      ld_size <= BYTE;
      ld_data <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && fu_lsq.valid && fu_lsq.load) begin
        ld_addr <= fu_lsq.addr;
        ld_size <= fu_lsq.mem_size;
        ld_data <= fwd_word;
      end
      if (state == WAIT && mem_rd_valid) ld_data <= mem_rd_data;
    end
  end

  always_comb begin
    state_next = state;
    mem_rd_req = 1'b0;
    lsq_fu     = '0;
    case (state)
      IDLE: begin
        if (!squash && fu_lsq.valid && fu_lsq.load && !fwd_unknown) begin
          if (!fwd_match)      state_next = REQ;
          else if (fwd_covers) state_next = FWD;
        end
      end
      FWD:  state_next = squash ? IDLE : DONE;
      REQ: begin
        mem_rd_req = !squash;
        if (squash)          state_next = IDLE;
        else if (mem_rd_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (squash)            state_next = mem_rd_valid ? IDLE : DROP;
        else if (mem_rd_valid) state_next = DONE;
      end
      DONE: begin
        lsq_fu.valid = !squash;
        lsq_fu.value = squash ? '0
                     : (ld_data >> {ld_addr[1:0], 3'b000}) & size_mask(ld_size);
        state_next   = IDLE;
      end
      DROP: if (mem_rd_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
